video_fetch_timing: RTL and testbench
=====================================

Name: video_fetch_timing

Overview:
- Parametrised raster timing and video-memory fetch-address generator.
- Successor to the fixed 640x480 counter/address logic in the HDMI output path.
- Generalises resolution and porches; selects text mode or one of two bitmap scale factors at run time.
- Adds a frame-latched scroll base address and a configurable pipeline delay. The delay aligns sync and draw-area signals with memory and character-ROM read latency before the RGB332 converter and TMDS encoders.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
AW, 17, video-memory address width
CHAR_W, 8, character cell width; power of 2
CHAR_H, 8, character cell height; power of 2
FETCH_LAT, 2, cycles from vmem_addr to pixel data valid at converter input; minimum 1

Ports:
pixclk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
mode_in  in  2  00 text, 01 bitmap x4 scale, 10 bitmap x2 scale, 11 treated as 01
scroll_base  in  AW  start address of the first displayed cell or pixel
vmem_addr  out  AW  video-memory read address
chr_row  out  log2(CHAR_H)  glyph row inside the cell; drives the character-ROM low address bits
chr_col  out  log2(CHAR_W)  glyph column inside the cell; selects the bit of the glyph row
draw_area  out  1  active video, delayed FETCH_LAT cycles
hsync  out  1  active-high horizontal sync, delayed FETCH_LAT cycles
vsync  out  1  active-high vertical sync, delayed FETCH_LAT cycles
frame_start  out  1  one-cycle pulse at cx=0, cy=0, undelayed
mode_active  out  2  mode in force for the current frame

Behaviour:
Totals:
- H_TOTAL = sum of the four H_* parameters; V_TOTAL likewise.
- Counters: cx in 0..H_TOTAL-1; cy in 0..V_TOTAL-1.
- cx wraps to 0 at H_TOTAL-1; cy increments on that wrap and wraps to 0 at V_TOTAL-1.

Reset:
- cx=0, cy=0, row_base=0, base_l=0, mode_active=00.
- All outputs 0, including every stage of the delay pipelines.
- Reset asserted mid-frame: identical result on the next edge. First frame_start occurs on the first cycle after reset deasserts.

Frame latch:
- On cx=H_TOTAL-1 and cy=V_TOTAL-1: base_l<=scroll_base, row_base<=scroll_base, mode_active<=mode_in (11 mapped to 01).
- Changes to scroll_base or mode_in at any other time are ignored.

Mode geometry (per mode_active):
- Text: cell width SX=CHAR_W, sub-rows SY=CHAR_H, cells per line N=H_ACTIVE/CHAR_W.
- Bitmap x4: SX=SY=4, N=H_ACTIVE/4.
- Bitmap x2: SX=SY=2, N=H_ACTIVE/2.

Address (one register stage):
- Active (cx<H_ACTIVE and cy<V_ACTIVE): vmem_addr <= row_base + cx/SX.
- Otherwise: vmem_addr <= row_base (prefetch the next line's first cell).
- Row advance: at cx=H_ACTIVE-1, cy<V_ACTIVE and (cy mod SY)=SY-1, row_base <= row_base + N.
- All address arithmetic is modulo 2^AW; wrap past the top of memory is silent.
- Frame latch takes priority over row advance. The two cannot coincide at legal parameters; the priority is still required.

Delayed signals:
- Raw terms: draw_raw = active; hs_raw = H_ACTIVE+H_FP <= cx < H_ACTIVE+H_FP+H_SYNC; vs_raw likewise on cy.
- draw_raw, hs_raw, vs_raw, cy mod CHAR_H and cx mod CHAR_W pass through a FETCH_LAT-deep shift register to draw_area, hsync, vsync, chr_row and chr_col respectively.
- chr_row and chr_col carry mod-CHAR values in every mode; they are meaningful only in text mode.

Latency:
- vmem_addr for pixel (cx,cy) is valid 1 cycle after the counters hold (cx,cy).
- draw_area/hsync/vsync/chr_* for that pixel are valid FETCH_LAT cycles after the counters hold it.

Test Plan:
1. Reset 3 cycles, default params, mode 00, base 0 -> frame_start pulse every 420000 cycles; hsync high 96 cycles per 800; vsync high for lines 490-491, delayed 2 cycles; draw_area high 640x480 cycles per frame.
2. Text mode, base 0 -> on line cy=0, vmem_addr steps 0,1..79, each value held 8 cycles; lines 0-7 repeat 0..79; line 8 starts at 80; line 479 shows 4720..4799; chr_row=cy mod 8 after 2-cycle delay.
3. Bitmap x4, base 0x1FFF0 -> first line addresses 0x1FFF0..0x1FFFF then 0x00000..0x0008F (wrap at AW=17); line 4 starts at 0x00090.
4. Bitmap x2 -> line 2 starts at 320; last visible line 479 ends at 76799.
5. Change mode_in 00->01 and scroll_base 0->500 at cy=100 -> no effect until the next frame; mode_active=01 and first vmem_addr=500 from the next frame_start.
6. Assert reset for 1 cycle at cx=300, cy=200 -> next cycle all outputs 0, counters 0; timing restarts exactly as in scenario 1.

Source files
------------

// File: rtl/video_fetch_timing.sv
// Raster timing and video-memory fetch-address generator with run-time mode select and frame-latched scroll base.
// Latency: vmem_addr is 1 cycle behind the raster counters; draw_area/hsync/vsync/chr_* are FETCH_LAT cycles behind.
// Backpressure: none; free-running off pixclk and always advancing.
//
// Ports:
//   pixclk, reset        pixel clock, synchronous active-high reset
//   mode_in, scroll_base sampled only on the last pixel of a frame
//   vmem_addr            video-memory read address (cell index in text mode, pixel-group index in bitmap modes)
//   chr_row, chr_col     glyph row/column inside the character cell, aligned with draw_area
//   draw_area, hsync, vsync  delayed raster qualifiers
//   frame_start          undelayed pulse while the counters sit at (0,0)
//   mode_active          mode in force for the current frame
module video_fetch_timing #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int AW        = 17,
  parameter int CHAR_W    = 8,
  parameter int CHAR_H    = 8,
  parameter int FETCH_LAT = 2
) (
  input  logic                      pixclk,
  input  logic                      reset,
  input  logic [1:0]                mode_in,
  input  logic [AW-1:0]             scroll_base,
  output logic [AW-1:0]             vmem_addr,
  output logic [$clog2(CHAR_H)-1:0] chr_row,
  output logic [$clog2(CHAR_W)-1:0] chr_col,
  output logic                      draw_area,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      frame_start,
  output logic [1:0]                mode_active
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int RW      = $clog2(CHAR_H);
  localparam int CW      = $clog2(CHAR_W);
  localparam int PW      = 3 + RW + CW;

  localparam logic [1:0]    MODE_X4 = 2'b01;
  localparam logic [1:0]    MODE_X2 = 2'b10;
  localparam logic [AW-1:0] N_TEXT  = AW'(H_ACTIVE / CHAR_W);
  localparam logic [AW-1:0] N_X4    = AW'(H_ACTIVE / 4);
  localparam logic [AW-1:0] N_X2    = AW'(H_ACTIVE / 2);

  logic [HW-1:0] cx;
  logic [VW-1:0] cy;
  logic [AW-1:0] row_base;

  logic [31:0]   cx32, cy32;
  logic          active, line_end, frame_end, sub_last, row_adv, hs_raw, vs_raw;
  logic [AW-1:0] col, cells;
  logic [VW-1:0] ymask;
  logic [PW-1:0] pipe_in;
  logic [PW-1:0] pipe [FETCH_LAT];

  always_comb begin
    cx32 = 32'(cx);
    cy32 = 32'(cy);

    active    = (cx32 < H_ACTIVE) && (cy32 < V_ACTIVE);
    line_end  = (cx32 == H_TOTAL - 1);
    frame_end = line_end && (cy32 == V_TOTAL - 1);
    hs_raw    = (cx32 >= H_ACTIVE + H_FP) && (cx32 < H_ACTIVE + H_FP + H_SYNC);
    vs_raw    = (cy32 >= V_ACTIVE + V_FP) && (cy32 < V_ACTIVE + V_FP + V_SYNC);

    // Cell geometry; all widths/heights are powers of two so division is a shift
    // and "cy mod SY == SY-1" is an all-ones test on the low bits.
    case (mode_active)
      MODE_X4: begin
        col   = AW'(cx >> 2);
        cells = N_X4;
        ymask = VW'(3);
      end
      MODE_X2: begin
        col   = AW'(cx >> 1);
        cells = N_X2;
        ymask = VW'(1);
      end
      default: begin
        col   = AW'(cx >> CW);
        cells = N_TEXT;
        ymask = VW'(CHAR_H - 1);
      end
    endcase

    sub_last = ((cy & ymask) == ymask);
    // Advance on the last visible pixel so the blanking interval already
    // prefetches the first cell of the next cell row.
    row_adv  = (cx32 == H_ACTIVE - 1) && (cy32 < V_ACTIVE) && sub_last;

    pipe_in  = {active, hs_raw, vs_raw, RW'(cy), CW'(cx)};
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      cx          <= '0;
      cy          <= '0;
      row_base    <= '0;
      mode_active <= '0;
      vmem_addr   <= '0;
      for (int i = 0; i < FETCH_LAT; i++) pipe[i] <= '0;
    end else begin
      cx <= line_end ? '0 : cx + 1'b1;
      if (line_end) cy <= (cy32 == V_TOTAL - 1) ? '0 : cy + 1'b1;

      vmem_addr <= active ? row_base + col : row_base;

      // Frame latch wins over the row advance.
      if (frame_end) begin
        row_base    <= scroll_base;
        mode_active <= (mode_in == 2'b11) ? MODE_X4 : mode_in;
      end else if (row_adv) begin
        row_base <= row_base + cells;
      end

      pipe[0] <= pipe_in;
      for (int i = 1; i < FETCH_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {draw_area, hsync, vsync, chr_row, chr_col} = pipe[FETCH_LAT-1];

  // Gated by reset so the pulse stays low while reset is held and appears in
  // the first cycle reset is released with the counters still at (0,0).
  assign frame_start = ~reset & (cx == '0) & (cy == '0);

endmodule

// File: tb/tb_video_fetch_timing.sv
module tb_video_fetch_timing;

  localparam int HA = 32, HF = 4, HS = 6, HB = 6;
  localparam int VA = 24, VF = 2, VS = 2, VB = 3;
  localparam int AW = 10, CW = 8, CH = 8, FL = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int NCYC = 40000;

  logic          pixclk = 1'b0;
  logic          reset;
  logic [1:0]    mode_in;
  logic [AW-1:0] scroll_base;
  logic [AW-1:0] vmem_addr;
  logic [2:0]    chr_row;
  logic [2:0]    chr_col;
  logic          draw_area, hsync, vsync, frame_start;
  logic [1:0]    mode_active;

  video_fetch_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .AW(AW), .CHAR_W(CW), .CHAR_H(CH), .FETCH_LAT(FL)
  ) dut (
    .pixclk(pixclk), .reset(reset), .mode_in(mode_in), .scroll_base(scroll_base),
    .vmem_addr(vmem_addr), .chr_row(chr_row), .chr_col(chr_col),
    .draw_area(draw_area), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .mode_active(mode_active)
  );

  always #5 pixclk = ~pixclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Address the fetcher should issue for raster position p of a frame drawn
  // with mode m and base b: cell row = completed sub-row groups, column = x/SX.
  function automatic int exp_addr(input int p, input int m, input int b);
    int x, y, sx, sy, n, a;
    x  = p % HT;
    y  = p / HT;
    sx = (m == 1) ? 4 : (m == 2) ? 2 : CW;
    sy = (m == 0) ? CH : sx;
    n  = HA / sx;
    if (y < VA && x < HA) a = b + n * (y / sy) + x / sx;
    else if (y < VA)      a = b + n * ((y + 1) / sy);
    else                  a = b + n * (VA / sy);
    return a % (1 << AW);
  endfunction

  int tbl_m [5] = '{1, 2, 3, 0, 2};
  int tbl_b [5] = '{1020, 1000, 5, 0, 1023};

  initial begin
    int n, p, q, x, y;
    int cur_mode, cur_base, prev_addr, frames, latch_idx, rst_hold;
    bit injected;
    int e_draw, e_hs, e_vs, e_row, e_col;

    n = 0; cur_mode = 0; cur_base = 0; prev_addr = 0;
    frames = 0; latch_idx = 0; injected = 0;
    rst_hold = 3;
    reset = 1'b1; mode_in = 2'b00; scroll_base = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge pixclk);
      // Model advance for the edge just taken.
      if (reset) begin
        n = 0; cur_mode = 0; cur_base = 0;
      end else begin
        prev_addr = exp_addr(n % FR, cur_mode, cur_base);
        if (n % FR == FR - 1) begin
          cur_mode = (mode_in == 2'b11) ? 1 : int'(mode_in);
          cur_base = int'(scroll_base);
          frames++;
        end
        n++;
      end

      #1;
      p = n % FR;
      if (rst_hold > 0) rst_hold--;
      else if ((!injected && frames == 6 && p == 20 + 10 * HT) || $urandom_range(0, 7999) == 0) begin
        rst_hold = 1;
        injected = 1;
      end
      reset = (rst_hold > 0);

      // Mid-frame noise on the latched inputs; only the last pixel matters.
      if ($urandom_range(0, 39) == 0) begin
        mode_in     = 2'($urandom_range(0, 3));
        scroll_base = AW'($urandom_range(0, (1 << AW) - 1));
      end
      if (p == FR - 1 && latch_idx < 5) begin
        mode_in     = 2'(tbl_m[latch_idx]);
        scroll_base = AW'(tbl_b[latch_idx]);
        latch_idx++;
      end

      @(negedge pixclk);
      check("frame_start", 32'(frame_start), 32'(p == 0 && !reset));
      check("mode_active", 32'(mode_active), 32'(cur_mode));
      check("vmem_addr", 32'(vmem_addr), (n == 0) ? 32'd0 : 32'(prev_addr));

      e_draw = 0; e_hs = 0; e_vs = 0; e_row = 0; e_col = 0;
      if (n >= FL) begin
        q = (n - FL) % FR;
        x = q % HT;
        y = q / HT;
        e_draw = (x < HA && y < VA) ? 1 : 0;
        e_hs   = (x >= HA + HF && x < HA + HF + HS) ? 1 : 0;
        e_vs   = (y >= VA + VF && y < VA + VF + VS) ? 1 : 0;
        e_row  = y % CH;
        e_col  = x % CW;
      end
      check("draw_area", 32'(draw_area), 32'(e_draw));
      check("hsync", 32'(hsync), 32'(e_hs));
      check("vsync", 32'(vsync), 32'(e_vs));
      check("chr_row", 32'(chr_row), 32'(e_row));
      check("chr_col", 32'(chr_col), 32'(e_col));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
